muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
Sequencer between the multicycle CPU control unit and the iterative mult/div units. Accepts MULT/DIV/MFHI/MFLO requests and owns the architectural HI/LO registers. Issues one-cycle start pulses, holds operands stable, and waits for done. Commits results, and reports divide-by-zero and hang (timeout) conditions to the exception logic.

Parameters:
TIMEOUT_CYCLES, 40, max cycles in WAIT before declaring the unit hung (covers 32-iteration divider plus margin)
WIDTH, 32, data width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  control unit presents an operation
req_op  in  2  00 MULT, 01 DIV, 10 MFHI, 11 MFLO
req_ready  out  1  request accepted this cycle when req_valid && req_ready
rs_val  in  WIDTH  operand A (dividend/multiplicand), sampled on acceptance
rt_val  in  WIDTH  operand B, sampled on acceptance
op_a  out  WIDTH  registered operand A to both units
op_b  out  WIDTH  registered operand B to both units
mult_start  out  1  one-cycle start pulse to multiplier
div_start  out  1  one-cycle start pulse to divider (drives DivCtrl)
mult_done  in  1  multiplier result valid
mult_hi  in  WIDTH  multiplier upper word
mult_lo  in  WIDTH  multiplier lower word
div_done  in  1  divider result valid
div_zero  in  1  divider reports zero divisor
div_hi  in  WIDTH  remainder
div_lo  in  WIDTH  quotient
rd_valid  out  1  MFHI/MFLO data valid (one cycle)
rd_data  out  WIDTH  HI or LO value for MFHI/MFLO
hi_q  out  WIDTH  architectural HI
lo_q  out  WIDTH  architectural LO
busy  out  1  operation in flight; CPU stalls on it
exc_div_zero  out  1  one-cycle divide-by-zero exception pulse
timeout_err  out  1  sticky hang flag

Behaviour:
- Reset (reset=0, async): state IDLE. All outputs 0: hi_q, lo_q, op_a, op_b, rd_data, starts, rd_valid, busy, exc_div_zero, timeout_err. Counter cleared. Reset mid-operation aborts silently; a late done after reset release is ignored.
- States: IDLE, ISSUE, WAIT.
- req_ready = (state==IDLE). busy = (state!=IDLE).
- IDLE, MFHI/MFLO accepted at edge N: rd_valid=1 with rd_data=hi_q (or lo_q) in cycle N+1. State stays IDLE. Back-to-back reads are allowed every cycle.
- IDLE, MULT/DIV accepted at edge N: latch op_a/op_b and op kind. Go to ISSUE.
- ISSUE: exactly one of mult_start/div_start is high for one cycle (registered). Load counter=TIMEOUT_CYCLES. Go to WAIT.
- op_a/op_b are held stable from ISSUE through WAIT.
- WAIT priority, evaluated per cycle; only the active unit's signals are sampled:
  1. DIV and div_zero=1: exc_div_zero pulses 1 cycle. HI/LO unchanged. Go to IDLE.
  2. done=1: hi_q/lo_q take unit hi/lo at that edge. Go to IDLE; req_ready=1 the next cycle.
  3. counter==1: timeout_err set (sticky until reset). HI/LO unchanged. Go to IDLE.
  4. Otherwise decrement counter.
- div_zero and div_done in the same cycle: div_zero wins.
- done/div_zero seen in IDLE or ISSUE, or from the inactive unit: ignored.
- Total latency MULT/DIV: acceptance N, start N+1, unit latency L, commit at done edge, ready again the cycle after.

Decomposition:
- Package muldiv_pkg:
  - op encoding localparams OP_MULT/OP_DIV/OP_MFHI/OP_MFLO
  - state encoding S_IDLE/S_ISSUE/S_WAIT
  - default TIMEOUT_CYCLES
- Sub-module muldiv_watchdog: load/decrement/expire counter, width clog2(TIMEOUT_CYCLES+1).

Test Plan:
- DIV rs=100, rt=7 with real divider: div_start high exactly 1 cycle, busy throughout; after div_done, lo_q=14, hi_q=2; req_ready returns 1 the next cycle.
- DIV rs=-7 (0xFFFFFFF9), rt=2: lo_q=0xFFFFFFFD, hi_q=0xFFFFFFFF; then MFLO gives rd_valid one cycle later with rd_data=0xFFFFFFFD.
- Preload HI=5, LO=9, then DIV rt=0: exc_div_zero one-cycle pulse; hi_q=5 and lo_q=9 unchanged; timeout_err=0.
- MFHI held on req_valid while MULT in flight (mock done after 10 cycles, hi=0x1234): req_ready=0 until commit; MFHI then returns 0x1234.
- MULT with mock never asserting done: timeout_err rises exactly TIMEOUT_CYCLES cycles after mult_start and stays high; next request accepted.
- Assert reset=0 mid-WAIT: all outputs 0 immediately without a clock edge; mock done after release does not change hi_q/lo_q.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the mult/div sequencer: request opcodes, FSM state
// encoding and default sizing.
package muldiv_pkg;

   localparam int unsigned WIDTH_DEF   = 32;
   localparam int unsigned TIMEOUT_DEF = 40;

   // Request opcodes presented on req_op
   localparam logic [1:0] OP_MULT = 2'b00;
   localparam logic [1:0] OP_DIV  = 2'b01;
   localparam logic [1:0] OP_MFHI = 2'b10;
   localparam logic [1:0] OP_MFLO = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_e;

endpackage

// File: rtl/muldiv_watchdog.sv
// Hang watchdog for the mult/div sequencer: loads TIMEOUT_CYCLES, counts down
// while an operation is outstanding and flags the final cycle of the budget.
// Ports:
//   clk, rst_n : clock, async active-low reset (clears the counter)
//   load_i     : reload counter with TIMEOUT_CYCLES
//   dec_i      : decrement counter (saturates at zero)
//   expire_o   : counter currently equals 1 (decoded from the counter register)
module muldiv_watchdog
   import muldiv_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_i,
   input  logic dec_i,
   output logic expire_o
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;

   // Load has priority over decrement
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= CNT_W'(TIMEOUT_CYCLES);
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign expire_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer between the CPU control unit and the iterative multiplier/divider.
// Owns the architectural HI/LO registers, serves MFHI/MFLO directly from them,
// and for MULT/DIV latches operands, pulses the unit's start, waits for done
// and commits. Divide-by-zero and watchdog expiry are reported without
// touching HI/LO.
// Ports:
//   clk, reset                     : clock, async active-low reset
//   req_valid/req_op/req_ready     : request handshake from control unit
//   rs_val/rt_val                  : operands, sampled on acceptance
//   op_a/op_b                      : held operands to both units
//   mult_start/div_start           : one-cycle start pulses
//   mult_done/mult_hi/mult_lo      : multiplier result
//   div_done/div_zero/div_hi/div_lo: divider result and zero-divisor flag
//   rd_valid/rd_data               : MFHI/MFLO result (one cycle)
//   hi_q/lo_q                      : architectural HI/LO
//   busy                           : operation in flight
//   exc_div_zero                   : one-cycle divide-by-zero pulse
//   timeout_err                    : sticky hang flag
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF,
   parameter int unsigned WIDTH          = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   input  logic [1:0]       req_op,
   output logic             req_ready,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   output logic             mult_start,
   output logic             div_start,
   input  logic             mult_done,
   input  logic [WIDTH-1:0] mult_hi,
   input  logic [WIDTH-1:0] mult_lo,
   input  logic             div_done,
   input  logic             div_zero,
   input  logic [WIDTH-1:0] div_hi,
   input  logic [WIDTH-1:0] div_lo,
   output logic             rd_valid,
   output logic [WIDTH-1:0] rd_data,
   output logic [WIDTH-1:0] hi_q,
   output logic [WIDTH-1:0] lo_q,
   output logic             busy,
   output logic             exc_div_zero,
   output logic             timeout_err
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   logic             is_div_q, is_div_d;
   logic [WIDTH-1:0] hi_d, lo_d;
   logic             rd_valid_q, rd_valid_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;
   logic             mult_start_q, mult_start_d;
   logic             div_start_q, div_start_d;
   logic             exc_q, exc_d;
   logic             tmo_q, tmo_d;
   logic             wd_load, wd_dec, wd_expire;

   // Only the unit that was started is observed
   logic             unit_done;
   logic [WIDTH-1:0] unit_hi, unit_lo;

   assign unit_done = is_div_q ? div_done : mult_done;
   assign unit_hi   = is_div_q ? div_hi   : mult_hi;
   assign unit_lo   = is_div_q ? div_lo   : mult_lo;

   muldiv_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk      (clk),
      .rst_n    (reset),
      .load_i   (wd_load),
      .dec_i    (wd_dec),
      .expire_o (wd_expire)
   );

   // Next-state and registered-output logic
   always_comb begin
      state_d      = state_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      is_div_d     = is_div_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      rd_valid_d   = 1'b0;
      rd_data_d    = rd_data_q;
      mult_start_d = 1'b0;
      div_start_d  = 1'b0;
      exc_d        = 1'b0;
      tmo_d        = tmo_q;
      wd_load      = 1'b0;
      wd_dec       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               case (req_op)
                  OP_MFHI: begin
                     rd_valid_d = 1'b1;
                     rd_data_d  = hi_q;
                  end
                  OP_MFLO: begin
                     rd_valid_d = 1'b1;
                     rd_data_d  = lo_q;
                  end
                  default: begin
                     op_a_d   = rs_val;
                     op_b_d   = rt_val;
                     is_div_d = (req_op == OP_DIV);
                     state_d  = S_ISSUE;
                  end
               endcase
            end
         end
         S_ISSUE: begin
            // Start pulse and watchdog load land on the same edge
            mult_start_d = !is_div_q;
            div_start_d  = is_div_q;
            wd_load      = 1'b1;
            state_d      = S_WAIT;
         end
         S_WAIT: begin
            if (is_div_q && div_zero) begin
               exc_d   = 1'b1;
               state_d = S_IDLE;
            end else if (unit_done) begin
               hi_d    = unit_hi;
               lo_d    = unit_lo;
               state_d = S_IDLE;
            end else if (wd_expire) begin
               tmo_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               wd_dec  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         op_a_q       <= '0;
         op_b_q       <= '0;
         is_div_q     <= 1'b0;
         hi_q         <= '0;
         lo_q         <= '0;
         rd_valid_q   <= 1'b0;
         rd_data_q    <= '0;
         mult_start_q <= 1'b0;
         div_start_q  <= 1'b0;
         exc_q        <= 1'b0;
         tmo_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         is_div_q     <= is_div_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         rd_valid_q   <= rd_valid_d;
         rd_data_q    <= rd_data_d;
         mult_start_q <= mult_start_d;
         div_start_q  <= div_start_d;
         exc_q        <= exc_d;
         tmo_q        <= tmo_d;
      end
   end

   // Handshake flags are pure decodes of the state register
   assign req_ready    = (state_q == S_IDLE);
   assign busy         = (state_q != S_IDLE);
   assign op_a         = op_a_q;
   assign op_b         = op_b_q;
   assign mult_start   = mult_start_q;
   assign div_start    = div_start_q;
   assign rd_valid     = rd_valid_q;
   assign rd_data      = rd_data_q;
   assign exc_div_zero = exc_q;
   assign timeout_err  = tmo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with behavioural multiplier/divider mocks
// and a scoreboard of expected HI/LO commits and MFHI/MFLO read data.
module tb_muldiv_ctrl;
   import muldiv_pkg::*;

   localparam int unsigned W   = 32;
   localparam int unsigned TMO = 40;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         req_valid, req_ready;
   logic [1:0]   req_op;
   logic [W-1:0] rs_val, rt_val, op_a, op_b;
   logic         mult_start, div_start;
   logic         mult_done = 1'b0;
   logic [W-1:0] mult_hi = '0, mult_lo = '0;
   logic         div_done = 1'b0, div_zero = 1'b0;
   logic [W-1:0] div_hi = '0, div_lo = '0;
   logic         rd_valid;
   logic [W-1:0] rd_data, hi_q, lo_q;
   logic         busy, exc_div_zero, timeout_err;

   int checks   = 0;
   int failures = 0;

   logic [2*W-1:0] exp_commit[$];
   logic [W-1:0]   exp_rd[$];

   muldiv_ctrl #(.TIMEOUT_CYCLES(TMO), .WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_op(req_op), .req_ready(req_ready),
      .rs_val(rs_val), .rt_val(rt_val), .op_a(op_a), .op_b(op_b),
      .mult_start(mult_start), .div_start(div_start),
      .mult_done(mult_done), .mult_hi(mult_hi), .mult_lo(mult_lo),
      .div_done(div_done), .div_zero(div_zero), .div_hi(div_hi), .div_lo(div_lo),
      .rd_valid(rd_valid), .rd_data(rd_data), .hi_q(hi_q), .lo_q(lo_q),
      .busy(busy), .exc_div_zero(exc_div_zero), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Mock multiplier: fixed latency, optional hang
   int           m_lat  = 3;
   bit           m_hang = 1'b0;
   logic [W-1:0] m_hi_v = '0, m_lo_v = '0;
   int           m_cnt  = 0;

   always @(posedge clk) begin
      mult_done <= 1'b0;
      if (mult_start) m_cnt <= m_lat;
      else if (m_cnt > 1) m_cnt <= m_cnt - 1;
      else if (m_cnt == 1) begin
         m_cnt <= 0;
         if (!m_hang) begin
            mult_done <= 1'b1;
            mult_hi   <= m_hi_v;
            mult_lo   <= m_lo_v;
         end
      end
   end

   // Mock signed divider, 34-cycle latency; zero divisor raises done and zero together
   int           d_cnt = 0;
   logic [W-1:0] d_a = '0, d_b = '0;

   always @(posedge clk) begin
      div_done <= 1'b0;
      div_zero <= 1'b0;
      if (div_start) begin
         d_cnt <= 34;
         d_a   <= op_a;
         d_b   <= op_b;
      end else if (d_cnt > 1) d_cnt <= d_cnt - 1;
      else if (d_cnt == 1) begin
         d_cnt    <= 0;
         div_done <= 1'b1;
         if (d_b == '0) begin
            div_zero <= 1'b1;
            div_hi   <= '1;
            div_lo   <= '1;
         end else begin
            div_lo <= W'($signed(d_a) / $signed(d_b));
            div_hi <= W'($signed(d_a) % $signed(d_b));
         end
      end
   end

   task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a MULT/DIV request (DUT idle), then wait for busy to drop
   task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int n;
      logic [2*W-1:0] e;
      req_op = op; rs_val = a; rt_val = b; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      n = 0;
      while (busy && n < 200) begin
         tick();
         n++;
      end
      check({tag, "_idle"}, 64'(busy), 64'(0));
      if (exp_commit.size() != 0) begin
         e = exp_commit.pop_front();
         check({tag, "_hilo"}, {hi_q, lo_q}, e);
      end
   endtask

   // MFHI/MFLO from idle: data valid exactly one cycle after acceptance
   task automatic do_read(input string tag, input logic [1:0] op, input logic [W-1:0] expv);
      exp_rd.push_back(expv);
      req_op = op; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      check({tag, "_rdv"}, 64'(rd_valid), 64'(1));
      if (rd_valid) check({tag, "_rdd"}, 64'(rd_data), 64'(exp_rd.pop_front()));
      tick();
      check({tag, "_rdv_drop"}, 64'(rd_valid), 64'(0));
   endtask

   initial begin
      int n, bad, starts;
      bit late_seen;
      req_valid = 1'b0; req_op = OP_MULT; rs_val = '0; rt_val = '0;

      // Reset values
      #1;
      check("rst_hilo", {hi_q, lo_q}, '0);
      check("rst_ops", {op_a, op_b}, '0);
      check("rst_rdd", 64'(rd_data), 64'(0));
      check("rst_flags", 64'({mult_start, div_start, rd_valid, busy, exc_div_zero, timeout_err}), 64'(0));
      check("rst_ready", 64'(req_ready), 64'(1));
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // DIV 100/7
      exp_commit.push_back({32'd2, 32'd14});
      req_op = OP_DIV; rs_val = 32'd100; rt_val = 32'd7; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      check("t1_issue_busy", 64'({busy, req_ready, div_start}), 64'(3'b100));
      tick();
      check("t1_start", 64'({div_start, mult_start}), 64'(2'b10));
      check("t1_ops", {op_a, op_b}, {32'd100, 32'd7});
      n = 0; starts = 0;
      while (busy && n < 200) begin
         tick();
         n++;
         if (div_start || mult_start) starts++;
      end
      check("t1_idle", 64'(busy), 64'(0));
      check("t1_single_pulse", 64'(starts), 64'(0));
      check("t1_hilo", {hi_q, lo_q}, exp_commit.pop_front());
      check("t1_ready", 64'(req_ready), 64'(1));

      // DIV -7/2 then MFLO
      exp_commit.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
      run_op("t2_div", OP_DIV, 32'hFFFF_FFF9, 32'd2);
      do_read("t2_mflo", OP_MFLO, 32'hFFFF_FFFD);

      // Preload HI=5/LO=9 through MULT, then DIV by zero
      m_lat = 3; m_hi_v = 32'd5; m_lo_v = 32'd9;
      exp_commit.push_back({32'd5, 32'd9});
      run_op("t3_pre", OP_MULT, 32'd3, 32'd3);
      req_op = OP_DIV; rs_val = 32'd123; rt_val = 32'd0; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      n = 0;
      while (!exc_div_zero && n < 100) begin
         tick();
         n++;
      end
      check("t3_exc", 64'({exc_div_zero, busy}), 64'(2'b10));
      tick();
      check("t3_exc_drop", 64'(exc_div_zero), 64'(0));
      check("t3_hilo", {hi_q, lo_q}, {32'd5, 32'd9});
      check("t3_tmo", 64'(timeout_err), 64'(0));

      // MFHI held while MULT in flight
      m_lat = 10; m_hi_v = 32'h1234; m_lo_v = 32'h55;
      exp_commit.push_back({32'h1234, 32'h55});
      req_op = OP_MULT; rs_val = 32'd7; rt_val = 32'd9; req_valid = 1'b1;
      tick();
      req_op = OP_MFHI;
      exp_rd.push_back(32'h1234);
      n = 0; bad = 0;
      while (!req_ready && n < 100) begin
         if (!busy) bad++;
         tick();
         n++;
      end
      check("t4_ready_only_idle", 64'(bad), 64'(0));
      check("t4_stalled", 64'(n > 10), 64'(1));
      check("t4_hilo", {hi_q, lo_q}, exp_commit.pop_front());
      tick();
      req_valid = 1'b0;
      check("t4_rdv", 64'(rd_valid), 64'(1));
      check("t4_rdd", 64'(rd_data), 64'(exp_rd.pop_front()));

      // MULT hang -> watchdog
      m_hang = 1'b1;
      req_op = OP_MULT; rs_val = 32'd1; rt_val = 32'd1; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      check("t5_issue", 64'(mult_start), 64'(0));
      tick();
      check("t5_start", 64'(mult_start), 64'(1));
      n = 0;
      while (!timeout_err && n < 100) begin
         tick();
         n++;
      end
      check("t5_tmo_cycles", 64'(n), 64'(TMO));
      check("t5_busy", 64'(busy), 64'(0));
      check("t5_hilo", {hi_q, lo_q}, {32'h1234, 32'h55});
      tick();
      check("t5_sticky", 64'(timeout_err), 64'(1));
      do_read("t5_mflo", OP_MFLO, 32'h55);
      check("t5_sticky2", 64'(timeout_err), 64'(1));

      // Reset mid-WAIT, late done ignored
      m_hang = 1'b0; m_lat = 10; m_hi_v = 32'hAAAA; m_lo_v = 32'hBBBB;
      req_op = OP_MULT; rs_val = 32'd2; rt_val = 32'd2; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      repeat (4) tick();
      check("t6_in_wait", 64'(busy), 64'(1));
      reset = 1'b0;
      #1;
      check("t6_rst_hilo", {hi_q, lo_q}, '0);
      check("t6_rst_ops", {op_a, op_b}, '0);
      check("t6_rst_flags", 64'({mult_start, div_start, rd_valid, busy, exc_div_zero, timeout_err}), 64'(0));
      @(posedge clk);
      #1 reset = 1'b1;
      late_seen = 1'b0;
      repeat (20) begin
         tick();
         if (mult_done) late_seen = 1'b1;
      end
      check("t6_late_done_seen", 64'(late_seen), 64'(1));
      check("t6_hilo", {hi_q, lo_q}, '0);
      check("t6_idle", 64'(busy), 64'(0));

      check("sb_empty", 64'(exp_commit.size() + exp_rd.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
